// File: rtl/mult_pkg.sv
// Types and widths shared by the sequential multiplier and its product serializer.
package mult_pkg;

    localparam int BW = 32;
    localparam int PW = 2 * BW;

    // 2'd3 is unused and recovers to S_IDLE.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LO   = 2'd1,
        S_HI   = 2'd2
    } ser_state_t;

endpackage

// File: rtl/product_serializer_if.sv
// Product-in / beat-out handshake bundle of the product serializer.
interface product_serializer_if #(
    parameter int BW = 32
);
    logic              i_prod_valid;
    logic [2*BW-1:0]   i_product;
    logic              o_prod_ready;
    logic              o_beat_valid;
    logic [BW-1:0]     o_beat_data;
    logic              o_beat_last;
    logic              i_beat_ready;

    modport slave (
        input  i_prod_valid,
        input  i_product,
        input  i_beat_ready,
        output o_prod_ready,
        output o_beat_valid,
        output o_beat_data,
        output o_beat_last
    );

    modport master (
        output i_prod_valid,
        output i_product,
        output i_beat_ready,
        input  o_prod_ready,
        input  o_beat_valid,
        input  o_beat_data,
        input  o_beat_last
    );
endinterface

// File: rtl/prod_fifo.sv
// Single-clock product FIFO; full/empty come from the occupancy count, not pointer compare.
module prod_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = mult_pkg::PW
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_push,
    input  logic [WIDTH-1:0]             i_data,
    input  logic                         i_pop,
    output logic [WIDTH-1:0]             o_head,
    output logic [WIDTH-1:0]             o_head_next,
    output logic [$clog2(DEPTH+1)-1:0]   o_count,
    output logic                         o_full,
    output logic                         o_empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic [AW-1:0]    w_rd_ptr_next;
    logic             w_push;
    logic             w_pop;

    assign o_full        = (r_count == CW'(DEPTH));
    assign o_empty       = (r_count == '0);
    assign w_push        = i_push & ~o_full;
    assign w_pop         = i_pop & ~o_empty;
    assign w_rd_ptr_next = r_rd_ptr + AW'(1);

    assign o_head      = r_mem[r_rd_ptr];
    assign o_head_next = r_mem[w_rd_ptr_next];
    assign o_count     = r_count;

    // Storage carries no reset; validity is tracked solely by the count.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= w_rd_ptr_next;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/product_serializer.sv
// Buffers 2*BW-bit products and streams each as a low beat then a high beat.
module product_serializer #(
    parameter int DEPTH = 4,
    parameter int BW    = mult_pkg::BW
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    product_serializer_if.slave          s_if,
    output logic                         o_overflow,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);
    import mult_pkg::*;

    localparam int LPW = 2 * BW;
    localparam int CW  = $clog2(DEPTH+1);

    ser_state_t       r_state;
    logic             r_beat_valid;
    logic             r_beat_last;
    logic [BW-1:0]    r_beat_data;
    logic             r_overflow;

    logic             w_push;
    logic             w_pop;
    logic             w_full;
    logic             w_empty;
    logic             w_more;
    logic             w_refill;
    logic [BW-1:0]    w_next_lo;
    logic [LPW-1:0]   w_head;
    logic [LPW-1:0]   w_head_next;
    logic [CW-1:0]    w_count;

    assign w_push = s_if.i_prod_valid & ~w_full;
    assign w_pop  = (r_state == S_HI) & s_if.i_beat_ready;

    // After popping the head, the next low word comes from the stored entry
    // behind it, or straight from a product landing on this same edge.
    assign w_more    = (w_count > CW'(1));
    assign w_refill  = w_more | w_push;
    assign w_next_lo = w_more ? w_head_next[BW-1:0] : s_if.i_product[BW-1:0];

    prod_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (LPW)
    ) u_fifo (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_push      (w_push),
        .i_data      (s_if.i_product),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_head_next (w_head_next),
        .o_count     (w_count),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_beat_valid <= 1'b0;
            r_beat_last  <= 1'b0;
            r_beat_data  <= '0;
            r_overflow   <= 1'b0;
        end else begin
            if (s_if.i_prod_valid && w_full) begin
                r_overflow <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    r_beat_valid <= 1'b0;
                    r_beat_last  <= 1'b0;
                    if (!w_empty) begin
                        r_state      <= S_LO;
                        r_beat_data  <= w_head[BW-1:0];
                        r_beat_valid <= 1'b1;
                    end
                end
                S_LO: begin
                    if (s_if.i_beat_ready) begin
                        r_state     <= S_HI;
                        r_beat_data <= w_head[LPW-1:BW];
                        r_beat_last <= 1'b1;
                    end
                end
                S_HI: begin
                    if (s_if.i_beat_ready) begin
                        if (w_refill) begin
                            r_state     <= S_LO;
                            r_beat_data <= w_next_lo;
                            r_beat_last <= 1'b0;
                        end else begin
                            r_state      <= S_IDLE;
                            r_beat_valid <= 1'b0;
                            r_beat_last  <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state      <= S_IDLE;
                    r_beat_valid <= 1'b0;
                    r_beat_last  <= 1'b0;
                end
            endcase
        end
    end

    assign s_if.o_prod_ready = ~w_full;
    assign s_if.o_beat_valid = r_beat_valid;
    assign s_if.o_beat_data  = r_beat_data;
    assign s_if.o_beat_last  = r_beat_last;
    assign o_overflow        = r_overflow;
    assign o_count           = w_count;

endmodule

// File: tb/tb_product_serializer.sv
// Directed bench for product_serializer: hand-computed beats, backpressure, overflow and reset.
module tb_product_serializer;

    localparam int DEPTH = 4;
    localparam int BW    = 32;

    logic        clk;
    logic        rst;
    logic        overflow;
    logic [2:0]  count;

    int checks   = 0;
    int failures = 0;

    product_serializer_if #(.BW(BW)) s_if ();

    product_serializer #(
        .DEPTH (DEPTH),
        .BW    (BW)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .s_if       (s_if.slave),
        .o_overflow (overflow),
        .o_count    (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    logic [63:0] full_p [5];
    logic [63:0] bp_p   [3];
    logic [31:0] exp_beat;
    logic [15:0] pat;
    logic [31:0] prev_data;
    logic        prev_last;
    logic        prev_stall;
    logic        accepted;
    int          idx;
    int          pushed;

    initial begin
        rst               = 1'b1;
        s_if.i_prod_valid = 1'b0;
        s_if.i_product    = '0;
        s_if.i_beat_ready = 1'b0;
        tick();
        tick();
        chk("rst_valid",    64'(s_if.o_beat_valid), 64'd0);
        chk("rst_data",     64'(s_if.o_beat_data),  64'd0);
        chk("rst_last",     64'(s_if.o_beat_last),  64'd0);
        chk("rst_overflow", 64'(overflow),          64'd0);
        chk("rst_count",    64'(count),             64'd0);
        chk("rst_ready",    64'(s_if.o_prod_ready), 64'd1);
        rst = 1'b0;
        tick();

        // Single positive product 12*13
        s_if.i_beat_ready = 1'b1;
        s_if.i_prod_valid = 1'b1;
        s_if.i_product    = 64'h0000_0000_0000_009C;
        tick();
        s_if.i_prod_valid = 1'b0;
        chk("pos_count_after_push", 64'(count), 64'd1);
        chk("pos_valid_after_push", 64'(s_if.o_beat_valid), 64'd0);
        tick();
        chk("pos_lo_valid", 64'(s_if.o_beat_valid), 64'd1);
        chk("pos_lo_data",  64'(s_if.o_beat_data),  64'h0000_009C);
        chk("pos_lo_last",  64'(s_if.o_beat_last),  64'd0);
        tick();
        chk("pos_hi_valid", 64'(s_if.o_beat_valid), 64'd1);
        chk("pos_hi_data",  64'(s_if.o_beat_data),  64'h0000_0000);
        chk("pos_hi_last",  64'(s_if.o_beat_last),  64'd1);
        tick();
        chk("pos_idle_valid", 64'(s_if.o_beat_valid), 64'd0);
        chk("pos_idle_count", 64'(count),             64'd0);

        // Negative product 12*-12
        s_if.i_prod_valid = 1'b1;
        s_if.i_product    = 64'hFFFF_FFFF_FFFF_FF70;
        tick();
        s_if.i_prod_valid = 1'b0;
        tick();
        chk("neg_lo_data", 64'(s_if.o_beat_data), 64'hFFFF_FF70);
        chk("neg_lo_last", 64'(s_if.o_beat_last), 64'd0);
        tick();
        chk("neg_hi_data", 64'(s_if.o_beat_data), 64'hFFFF_FFFF);
        chk("neg_hi_last", 64'(s_if.o_beat_last), 64'd1);
        tick();
        chk("neg_idle_valid", 64'(s_if.o_beat_valid), 64'd0);

        // Fill to DEPTH with the consumer stalled; the fifth product is dropped
        full_p[0] = 64'h1111_1111_A0A0_A0A0;
        full_p[1] = 64'h2222_2222_B1B1_B1B1;
        full_p[2] = 64'h3333_3333_C2C2_C2C2;
        full_p[3] = 64'h4444_4444_D3D3_D3D3;
        full_p[4] = 64'h5555_5555_E4E4_E4E4;
        s_if.i_beat_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            s_if.i_prod_valid = 1'b1;
            s_if.i_product    = full_p[i];
            tick();
            if (i == 2) begin
                chk("full_ready_at_3", 64'(s_if.o_prod_ready), 64'd1);
                chk("full_count_3",    64'(count),             64'd3);
            end
            if (i == 3) begin
                chk("full_ready_at_4", 64'(s_if.o_prod_ready), 64'd0);
                chk("full_count_4",    64'(count),             64'd4);
                chk("full_ovf_before", 64'(overflow),          64'd0);
            end
        end
        s_if.i_prod_valid = 1'b0;
        chk("full_ovf_set",     64'(overflow), 64'd1);
        chk("full_count_drop",  64'(count),    64'd4);
        chk("full_stall_data",  64'(s_if.o_beat_data), 64'hA0A0_A0A0);
        s_if.i_beat_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            exp_beat = (i % 2 == 0) ? full_p[i/2][31:0] : full_p[i/2][63:32];
            chk($sformatf("drain_valid_%0d", i), 64'(s_if.o_beat_valid), 64'd1);
            chk($sformatf("drain_data_%0d", i),  64'(s_if.o_beat_data),  64'(exp_beat));
            chk($sformatf("drain_last_%0d", i),  64'(s_if.o_beat_last),  64'(i % 2));
            tick();
        end
        chk("drain_done_valid", 64'(s_if.o_beat_valid), 64'd0);
        chk("drain_done_count", 64'(count),             64'd0);
        chk("drain_ovf_sticky", 64'(overflow),          64'd1);

        // Backpressure with a fixed irregular ready pattern
        bp_p[0] = 64'h0102_0304_0506_0708;
        bp_p[1] = 64'h8000_0001_7FFF_FFFE;
        bp_p[2] = 64'hDEAD_BEEF_CAFE_F00D;
        s_if.i_beat_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            s_if.i_prod_valid = 1'b1;
            s_if.i_product    = bp_p[i];
            tick();
        end
        s_if.i_prod_valid = 1'b0;
        pat        = 16'b1011_0010_1101_0011;
        idx        = 0;
        prev_stall = 1'b0;
        for (int c = 0; c < 48 && idx < 6; c++) begin
            if (s_if.o_beat_valid) begin
                exp_beat = (idx % 2 == 0) ? bp_p[idx/2][31:0] : bp_p[idx/2][63:32];
                chk($sformatf("bp_data_%0d", idx), 64'(s_if.o_beat_data), 64'(exp_beat));
                chk($sformatf("bp_last_%0d", idx), 64'(s_if.o_beat_last), 64'(idx % 2));
            end
            s_if.i_beat_ready = pat[c % 16];
            prev_stall = s_if.o_beat_valid & ~s_if.i_beat_ready;
            prev_data  = s_if.o_beat_data;
            prev_last  = s_if.o_beat_last;
            accepted   = s_if.o_beat_valid & s_if.i_beat_ready;
            tick();
            if (accepted) idx++;
            if (prev_stall) begin
                chk("bp_stable_data", 64'(s_if.o_beat_data), 64'(prev_data));
                chk("bp_stable_last", 64'(s_if.o_beat_last), 64'(prev_last));
            end
        end
        chk("bp_beats_seen",  64'(idx),                 64'd6);
        s_if.i_beat_ready = 1'b0;
        chk("bp_end_valid",   64'(s_if.o_beat_valid),   64'd0);
        chk("bp_end_count",   64'(count),               64'd0);

        // Streaming: a push every 2 cycles, consumer always ready
        s_if.i_beat_ready = 1'b1;
        pushed = 0;
        idx    = 0;
        for (int c = 0; c < 40 && idx < 20; c++) begin
            s_if.i_prod_valid = (c % 2 == 0) && (pushed < 10);
            s_if.i_product    = {32'hA000_0000 + 32'(pushed), 32'h0000_0100 + 32'(pushed)};
            tick();
            if (s_if.i_prod_valid) pushed++;
            if (s_if.o_beat_valid) begin
                exp_beat = (idx % 2 == 0) ? 32'h0000_0100 + 32'(idx/2) : 32'hA000_0000 + 32'(idx/2);
                chk($sformatf("stream_data_%0d", idx), 64'(s_if.o_beat_data), 64'(exp_beat));
                chk($sformatf("stream_last_%0d", idx), 64'(s_if.o_beat_last), 64'(idx % 2));
                idx++;
            end else if (idx > 0 && idx < 20) begin
                chk("stream_bubble", 64'(s_if.o_beat_valid), 64'd1);
            end
            chk("stream_count_max", 64'(count <= 3'd2), 64'd1);
        end
        chk("stream_beats", 64'(idx), 64'd20);
        s_if.i_prod_valid = 1'b0;
        tick();
        chk("stream_end_valid", 64'(s_if.o_beat_valid), 64'd0);
        chk("stream_end_count", 64'(count),             64'd0);

        // Reset while the high beat is pending with two entries stored
        s_if.i_beat_ready = 1'b0;
        s_if.i_prod_valid = 1'b1;
        s_if.i_product    = 64'h7777_0000_6666_0000;
        tick();
        s_if.i_product    = 64'h9999_0000_8888_0000;
        tick();
        s_if.i_prod_valid = 1'b0;
        s_if.i_beat_ready = 1'b1;
        tick();
        s_if.i_beat_ready = 1'b0;
        chk("mid_hi_last",  64'(s_if.o_beat_last), 64'd1);
        chk("mid_hi_data",  64'(s_if.o_beat_data), 64'h7777_0000);
        chk("mid_count",    64'(count),            64'd2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_valid",    64'(s_if.o_beat_valid), 64'd0);
        chk("mid_rst_last",     64'(s_if.o_beat_last),  64'd0);
        chk("mid_rst_count",    64'(count),             64'd0);
        chk("mid_rst_overflow", 64'(overflow),          64'd0);
        chk("mid_rst_ready",    64'(s_if.o_prod_ready), 64'd1);
        tick();
        chk("mid_rst_no_output", 64'(s_if.o_beat_valid), 64'd0);

        s_if.i_beat_ready = 1'b1;
        s_if.i_prod_valid = 1'b1;
        s_if.i_product    = 64'h0000_0001_8000_0005;
        tick();
        s_if.i_prod_valid = 1'b0;
        tick();
        chk("post_lo_data", 64'(s_if.o_beat_data), 64'h8000_0005);
        chk("post_lo_last", 64'(s_if.o_beat_last), 64'd0);
        tick();
        chk("post_hi_data", 64'(s_if.o_beat_data), 64'h0000_0001);
        chk("post_hi_last", 64'(s_if.o_beat_last), 64'd1);
        tick();
        chk("post_idle_valid", 64'(s_if.o_beat_valid), 64'd0);
        chk("post_idle_count", 64'(count),             64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
